// File: rtl/key_event_tracker.sv
// PS/2 set-2 key event tracker: decodes make/break sequences for a table of
// keys, keeps held-key state with a voice limit, and queues press/release events.
module key_event_tracker #(
  parameter int NUM_KEYS = 12,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h03B, 9'h03C, 9'h033, 9'h035, 9'h034, 9'h02C,
    9'h02B, 9'h023, 9'h024, 9'h01B, 9'h01D, 9'h01C},
  parameter int MODE       = 0,
  parameter int MAX_VOICES = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int CW = $clog2(NUM_KEYS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                byte_received,
  input  logic [7:0]          newest_byte,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [CW-1:0]       active_count,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW:0]         evt_data,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_MAKE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_SEC_MAKE  = 2'd2,
    ST_SEC_BREAK = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                is_prefix;
  logic                sec, brk;
  logic                hit;
  logic [KW-1:0]       hit_idx;
  logic [NUM_KEYS-1:0] key_nxt;
  logic                push;
  logic [KW:0]         push_data;

  // ---------------- decoder FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_MAKE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_received) begin
      if (newest_byte == 8'hE0) begin
        state_nxt = ST_SEC_MAKE;
      end else if (newest_byte == 8'hF0) begin
        case (state)
          ST_MAKE:     state_nxt = ST_BREAK;
          ST_SEC_MAKE: state_nxt = ST_SEC_BREAK;
          default:     state_nxt = state;
        endcase
      end else begin
        state_nxt = ST_MAKE;
      end
    end
  end

  assign is_prefix = (newest_byte == 8'hE0) || (newest_byte == 8'hF0);
  assign sec       = (state == ST_SEC_MAKE) || (state == ST_SEC_BREAK);
  assign brk       = (state == ST_BREAK)    || (state == ST_SEC_BREAK);

  // Lowest matching index wins: later entries only considered while no hit yet.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!hit && KEY_CODES[9*i +: 8] == newest_byte && KEY_CODES[9*i+8] == sec) begin
        hit     = 1'b1;
        hit_idx = KW'(i);
      end
    end
  end

  // ---------------- key state and event generation ----------------
  always_comb begin
    key_nxt   = key_state;
    push      = 1'b0;
    push_data = '0;
    if (byte_received && !is_prefix && hit) begin
      if (!brk) begin
        if (!key_state[hit_idx] && active_count < CW'(MAX_VOICES)) begin
          key_nxt[hit_idx] = 1'b1;
          push             = 1'b1;
          push_data        = {1'b1, hit_idx};
        end
      end else if (key_state[hit_idx]) begin
        key_nxt[hit_idx] = 1'b0;
        push             = 1'b1;
        push_data        = {1'b0, hit_idx};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) key_state <= '0;
    else       key_state <= key_nxt;
  end

  always_comb begin
    active_count = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      active_count = active_count + CW'(key_state[i]);
  end

  // Pulse modes register the edge from key_nxt so the pulse lands in the same
  // cycle that key_state first shows the new value.
  generate
    if (MODE == 1) begin : g_press
      always_ff @(posedge clock or posedge reset) begin
        if (reset) key_out <= '0;
        else       key_out <= key_nxt & ~key_state;
      end
    end else if (MODE == 2) begin : g_release
      always_ff @(posedge clock or posedge reset) begin
        if (reset) key_out <= '0;
        else       key_out <= ~key_nxt & key_state;
      end
    end else begin : g_hold
      assign key_out = key_state;
    end
  endgenerate

  // ---------------- event FIFO ----------------
  logic [KW:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, pop, wr_en, drop;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign pop   = evt_valid && evt_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign evt_valid = (count != '0);
  assign evt_data  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_key_event_tracker.sv
// Directed bench for key_event_tracker: three instances (hold / press pulse with
// a 2-deep FIFO / release pulse) share one stimulus stream.
module tb_key_event_tracker;

  logic clock = 1'b0;
  logic reset, byte_received, evt_ready, overflow_clr;
  logic [7:0] newest_byte;

  logic [11:0] a_ks, a_ko, b_ks, b_ko, c_ks, c_ko;
  logic [3:0]  a_ac, b_ac, c_ac;
  logic        a_v, b_v, c_v, a_ov, b_ov, c_ov;
  logic [4:0]  a_d, b_d, c_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  key_event_tracker #(.MODE(0), .FIFO_DEPTH(8)) dut_a (
    .clock(clock), .reset(reset), .byte_received(byte_received), .newest_byte(newest_byte),
    .key_state(a_ks), .key_out(a_ko), .active_count(a_ac), .evt_valid(a_v),
    .evt_ready(evt_ready), .evt_data(a_d), .overflow(a_ov), .overflow_clr(overflow_clr));

  key_event_tracker #(.MODE(1), .FIFO_DEPTH(2)) dut_b (
    .clock(clock), .reset(reset), .byte_received(byte_received), .newest_byte(newest_byte),
    .key_state(b_ks), .key_out(b_ko), .active_count(b_ac), .evt_valid(b_v),
    .evt_ready(evt_ready), .evt_data(b_d), .overflow(b_ov), .overflow_clr(overflow_clr));

  key_event_tracker #(.MODE(2), .FIFO_DEPTH(8)) dut_c (
    .clock(clock), .reset(reset), .byte_received(byte_received), .newest_byte(newest_byte),
    .key_state(c_ks), .key_out(c_ko), .active_count(c_ac), .evt_valid(c_v),
    .evt_ready(evt_ready), .evt_data(c_d), .overflow(c_ov), .overflow_clr(overflow_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b);
    byte_received = 1'b1;
    newest_byte   = b;
    @(negedge clock);
    byte_received = 1'b0;
    newest_byte   = 8'h00;
  endtask

  task automatic pop1();
    evt_ready = 1'b1;
    @(negedge clock);
    evt_ready = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; byte_received = 1'b0; newest_byte = 8'h00;
    evt_ready = 1'b0; overflow_clr = 1'b0;
    idle(); idle();
    chk("rst_key_state", a_ks, 0);
    chk("rst_active", a_ac, 0);
    chk("rst_valid", a_v, 0);
    chk("rst_overflow", a_ov, 0);
    chk("rst_key_out_b", b_ko, 0);
    reset = 1'b0;
    idle();

    // make then break of key 0
    send(8'h1C);
    chk("mk0_key_state", a_ks, 12'h001);
    chk("mk0_active", a_ac, 1);
    chk("mk0_valid", a_v, 1);
    chk("mk0_data", a_d, 5'h10);
    chk("mk0_press_pulse", b_ko, 12'h001);
    chk("mk0_hold_out", a_ko, 12'h001);
    idle();
    chk("mk0_press_pulse_end", b_ko, 12'h000);
    send(8'hF0);
    send(8'h1C);
    chk("br0_key_state", a_ks, 12'h000);
    chk("br0_release_pulse", c_ko, 12'h001);
    chk("br0_no_press_pulse", b_ko, 12'h000);
    idle();
    chk("br0_release_pulse_end", c_ko, 12'h000);
    chk("br0_head", a_d, 5'h10);
    pop1();
    chk("br0_second", a_d, 5'h00);
    chk("br0_second_valid", a_v, 1);
    pop1();
    chk("br0_empty", a_v, 0);
    chk("br0_b_noovf", b_ov, 0);

    // typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("typ_active", a_ac, 1);
    chk("typ_head", a_d, 5'h10);
    pop1();
    chk("typ_one_event", a_v, 0);
    send(8'hF0); send(8'h1C);
    pop1();
    chk("typ_cleared", a_ks, 0);
    chk("typ_empty", a_v, 0);

    // E0-prefixed codes do not match primary entries
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    chk("sec_key_state", a_ks, 0);
    chk("sec_no_event", a_v, 0);
    send(8'h1D);
    chk("sec_back_make", a_ks, 12'h002);
    chk("sec_back_data", a_d, 5'h11);
    send(8'hF0); send(8'h1D);
    pop1(); pop1();
    chk("sec_empty", a_v, 0);

    // voice limit and the 2-deep FIFO overflow
    send(8'h1C); send(8'h1D); send(8'h1B);
    chk("ovf_b_key_state", b_ks, 12'h007);
    chk("ovf_b_set", b_ov, 1);
    chk("ovf_a_clear", a_ov, 0);
    chk("ovf_b_head", b_d, 5'h10);
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("ovf_clr", b_ov, 0);
    overflow_clr = 1'b1;
    send(8'h24);
    overflow_clr = 1'b0;
    chk("ovf_drop_beats_clr", b_ov, 1);
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("ovf_clr2", b_ov, 0);
    send(8'h23);
    chk("voice_key4_clear", a_ks, 12'h00F);
    chk("voice_active", a_ac, 4);
    chk("voice_no_ovf", b_ov, 0);
    send(8'hF0); send(8'h23);
    chk("voice_break_ignored", a_ks, 12'h00F);

    // push into full FIFO with simultaneous pop
    send(8'hF0);
    chk("pp_a_head", a_d, 5'h10);
    evt_ready = 1'b1;
    send(8'h1C);
    evt_ready = 1'b0;
    chk("pp_b_noovf", b_ov, 0);
    chk("pp_key_state", a_ks, 12'h00E);
    chk("pp_b_head", b_d, 5'h11);
    chk("pp_a_head2", a_d, 5'h11);
    pop1();
    chk("pp_a_e2", a_d, 5'h12);
    chk("pp_b_e2", b_d, 5'h00);
    pop1();
    chk("pp_a_e3", a_d, 5'h13);
    chk("pp_b_empty", b_v, 0);
    pop1();
    chk("pp_a_e4", a_d, 5'h00);
    pop1();
    chk("pp_a_empty", a_v, 0);

    // reset after a pending break prefix with 3 keys held
    chk("rs_held", a_ac, 3);
    send(8'hF0);
    reset = 1'b1;
    #1;
    chk("rs_async_key_state", a_ks, 0);
    idle();
    chk("rs_active", a_ac, 0);
    chk("rs_valid", a_v, 0);
    chk("rs_ovf", a_ov, 0);
    chk("rs_b_key_out", b_ko, 0);
    reset = 1'b0;
    idle();
    send(8'h1D);
    chk("rs_make_after", a_ks, 12'h002);
    chk("rs_make_data", a_d, 5'h11);
    chk("rs_make_pulse", b_ko, 12'h002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
